// File: rtl/seq_detector_param.sv
// Serial pattern detector (Mealy): z flags the completing bit in the same cycle, z_q one cycle later.
// No backpressure: a bit is consumed on every en=1 edge; clear outranks en; match counter saturates.
module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             clear,
  output logic             z,
  output logic             z_q,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int SW = $clog2(PAT_W);
  localparam int NS = 1 << SW;

  if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
    $error("seq_detector_param: PAT_W must be in 2..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W must be in 1..32");
  end

  // Longest suffix of (matched prefix of length s, then bit b) that is a proper prefix of PATTERN.
  function automatic int kmp_next(input int s, input int b);
    int best;
    int lim;
    int si;
    int sbit;
    logic ok;
    best = 0;
    if (s < PAT_W) begin
      lim = (s + 1 < PAT_W - 1) ? s + 1 : PAT_W - 1;
      for (int k = 1; k <= lim; k++) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          si   = s + 1 - k + j;
          sbit = (si == s) ? b : int'(PATTERN[PAT_W-1-si]);
          if (sbit != int'(PATTERN[PAT_W-1-j])) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  localparam logic [SW-1:0]    LAST    = SW'(PAT_W - 1);
  localparam logic [SW-1:0]    BORDER  = SW'(kmp_next(PAT_W - 1, int'(PATTERN[0])));
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((64'd1 << CNT_W) - 64'd1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'((64'd1 << CNT_W) - 64'd2);

  logic [SW-1:0] tbl0 [NS];
  logic [SW-1:0] tbl1 [NS];
  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;

  for (genvar g = 0; g < NS; g++) begin : g_tbl
    assign tbl0[g] = SW'(kmp_next(g, 0));
    assign tbl1[g] = SW'(kmp_next(g, 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    z       = en & ~clear & (state_q == LAST) & (x == PATTERN[0]);
    state_d = state_q;
    if (clear) begin
      state_d = '0;
    end else if (en) begin
      if (z) begin
        state_d = overlap ? BORDER : '0;
      end else begin
        state_d = x ? tbl1[state_q] : tbl0[state_q];
      end
    end
  end

  // Counter stops at all-ones; the sat flag latches on the edge it gets there.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      z_q         <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      z_q <= z;
      if (clear) begin
        match_count <= '0;
        count_sat   <= 1'b0;
      end else if (z && match_count != CNT_MAX) begin
        match_count <= match_count + CNT_W'(1);
        if (match_count == CNT_PRE) count_sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed-vector bench for seq_detector_param: three instances (default, 2-bit counter, 10100 pattern).
module tb_seq_detector_param;

  logic       clk;
  logic       rstn;
  logic [2:0] en_v;
  logic [2:0] x_v;
  logic [2:0] ov_v;
  logic [2:0] cl_v;

  logic       z0, zq0, sat0;
  logic [7:0] cnt0;
  logic       z1, zq1, sat1;
  logic [1:0] cnt1;
  logic       z2, zq2, sat2;
  logic [7:0] cnt2;

  seq_detector_param dut0 (
    .clk(clk), .rstn(rstn), .en(en_v[0]), .x(x_v[0]), .overlap(ov_v[0]), .clear(cl_v[0]),
    .z(z0), .z_q(zq0), .match_count(cnt0), .count_sat(sat0)
  );

  seq_detector_param #(.CNT_W(2)) dut1 (
    .clk(clk), .rstn(rstn), .en(en_v[1]), .x(x_v[1]), .overlap(ov_v[1]), .clear(cl_v[1]),
    .z(z1), .z_q(zq1), .match_count(cnt1), .count_sat(sat1)
  );

  seq_detector_param #(.PAT_W(5), .PATTERN(5'b10100)) dut2 (
    .clk(clk), .rstn(rstn), .en(en_v[2]), .x(x_v[2]), .overlap(ov_v[2]), .clear(cl_v[2]),
    .z(z2), .z_q(zq2), .match_count(cnt2), .count_sat(sat2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int   sel;
    int   tag;
    logic z;
    logic zq;
    int   cnt;
    logic sat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   tag_n = 0;

  // Counter model state per instance (values visible during the next cycle).
  logic prev_z [3];
  int   cnt_m  [3];
  logic sat_m  [3];

  function automatic int cmax(input int sel);
    return (sel == 1) ? 3 : 255;
  endfunction

  task automatic check(input string nm, input int tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s tag=%0d actual=%0d expected=%0d", nm, tag, act, exp);
    end
  endtask

  task automatic reset_models();
    for (int i = 0; i < 3; i++) begin
      prev_z[i] = 1'b0;
      cnt_m[i]  = 0;
      sat_m[i]  = 1'b0;
    end
  endtask

  // One cycle on instance sel; the others idle with en=0.
  task automatic drive(input int sel, input logic e, input logic xb, input logic ov,
                       input logic cl, input logic ez);
    exp_t r;
    @(posedge clk);
    #1;
    en_v = '0; x_v = '0; ov_v = '0; cl_v = '0;
    en_v[sel] = e; x_v[sel] = xb; ov_v[sel] = ov; cl_v[sel] = cl;
    tag_n++;
    r.sel = sel; r.tag = tag_n; r.z = ez; r.zq = prev_z[sel];
    r.cnt = cnt_m[sel]; r.sat = sat_m[sel];
    sb.push_back(r);
    for (int i = 0; i < 3; i++) if (i != sel) prev_z[i] = 1'b0;
    prev_z[sel] = ez;
    if (cl) begin
      cnt_m[sel] = 0;
      sat_m[sel] = 1'b0;
    end else if (ez && cnt_m[sel] != cmax(sel)) begin
      cnt_m[sel]++;
      if (cnt_m[sel] == cmax(sel)) sat_m[sel] = 1'b1;
    end
  endtask

  // First bit is bits[n-1]; zexp uses the same layout.
  task automatic stream(input int sel, input logic ov, input int n,
                        input logic [31:0] bits, input logic [31:0] zexp);
    for (int i = n - 1; i >= 0; i--) drive(sel, 1'b1, bits[i], ov, 1'b0, zexp[i]);
  endtask

  task automatic clr(input int sel);
    drive(sel, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: one scoreboard entry per driven cycle, sampled mid-cycle.
  exp_t m;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m = sb.pop_front();
      case (m.sel)
        0: begin
          check("z", m.tag, int'(z0), int'(m.z));
          check("z_q", m.tag, int'(zq0), int'(m.zq));
          check("match_count", m.tag, int'(cnt0), m.cnt);
          check("count_sat", m.tag, int'(sat0), int'(m.sat));
        end
        1: begin
          check("z", m.tag, int'(z1), int'(m.z));
          check("z_q", m.tag, int'(zq1), int'(m.zq));
          check("match_count", m.tag, int'(cnt1), m.cnt);
          check("count_sat", m.tag, int'(sat1), int'(m.sat));
        end
        default: begin
          check("z", m.tag, int'(z2), int'(m.z));
          check("z_q", m.tag, int'(zq2), int'(m.zq));
          check("match_count", m.tag, int'(cnt2), m.cnt);
          check("count_sat", m.tag, int'(sat2), int'(m.sat));
        end
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset_models();
    rstn = 1'b0;
    en_v = 3'b111; x_v = 3'b011; ov_v = '0; cl_v = '0;
    #3;
    check("rst_z0", 0, int'(z0), 0);
    check("rst_z2", 0, int'(z2), 0);
    check("rst_zq0", 0, int'(zq0), 0);
    check("rst_cnt0", 0, int'(cnt0), 0);
    check("rst_sat0", 0, int'(sat0), 0);
    #5;
    en_v = '0;
    rstn = 1'b1;

    // Non-overlap on the default pattern
    stream(0, 1'b0, 15, 32'b110101011101010, 32'b000100000001000);

    // Overlap off, then on
    clr(0);
    stream(0, 1'b0, 7, 32'b1101101, 32'b0001000);
    clr(0);
    stream(0, 1'b1, 7, 32'b1101101, 32'b0001001);

    // Enable gating holds a 3-bit prefix
    clr(0);
    stream(0, 1'b0, 3, 32'b110, 32'b000);
    for (int i = 0; i < 3; i++) drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // Async reset in the middle of a prefix
    stream(0, 1'b0, 3, 32'b110, 32'b000);
    @(posedge clk);
    #1;
    en_v = '0; x_v = '0; cl_v = '0; ov_v = '0;
    en_v[0] = 1'b1; x_v[0] = 1'b1;
    #1;
    check("pre_rst_z", 0, int'(z0), 1);
    check("pre_rst_cnt", 0, int'(cnt0), 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_z", 0, int'(z0), 0);
    check("mid_rst_zq", 0, int'(zq0), 0);
    check("mid_rst_cnt", 0, int'(cnt0), 0);
    check("mid_rst_sat", 0, int'(sat0), 0);
    en_v = '0;
    #1;
    rstn = 1'b1;
    reset_models();
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    stream(0, 1'b0, 4, 32'b1101, 32'b0001);

    // Saturation on the 2-bit counter, then clear beating a completing bit
    clr(1);
    stream(1, 1'b0, 20, {12'b0, {5{4'b1101}}}, {12'b0, {5{4'b0001}}});
    stream(1, 1'b0, 3, 32'b110, 32'b000);
    drive(1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stream(1, 1'b0, 4, 32'b1101, 32'b0001);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Five-bit pattern needing the 4 -> 3 fallback
    clr(2);
    stream(2, 1'b1, 7, 32'b1010100, 32'b0000001);
    drive(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Mealy serial-pattern detector for single-bit input streams. It is the generalised successor to the fixed 4-bit non-overlapping detector. It adds the following:
- a configurable pattern and length;
- run-time selection between overlapping and non-overlapping modes;
- a clock enable and a synchronous clear;
- a saturating match counter.

It sits on a serial bit lane and flags each pattern completion in the same cycle as the completing bit.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101, PAT_W-bit pattern; the MSB is the first bit received.
- CNT_W, 8, width of the match counter; legal range 1..32.

- clk  in  1  single system clock; rising edge.
- rstn  in  1  asynchronous, active-low reset.
- en  in  1  bit-valid qualifier; `x` is consumed only when en=1.
- x  in  1  serial data bit.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- clear  in  1  synchronous clear of the FSM state, the counter and the sat flag.
- z  out  1  Mealy match output (combinational).
- z_q  out  1  z registered one cycle later.
- match_count  out  CNT_W  number of matches, saturating.
- count_sat  out  1  sticky flag: the counter has reached its maximum value.

## Operation
- **State encoding:** the state is the matched-prefix length, 0..PAT_W-1, held in a binary register of width $clog2(PAT_W).
- **Matching bit:** on an en=1 cycle with state s, the matching bit is PATTERN[PAT_W-1-s].
- **Match condition:** z = en & ~clear & (s == PAT_W-1) & (x == PATTERN[0]).
- **Mismatch or partial progress:** the next state is the length of the longest suffix of (matched prefix, x) that is also a proper prefix of PATTERN. This is KMP failure-function behaviour. The transition table is computed at elaboration from PATTERN; no run-time search is performed.
- **Next state on a match:**
  - overlap=1: the longest proper border of PATTERN. For 1101 this is 1.
  - overlap=0: 0.
  - overlap is sampled only on the match cycle.
- **en=0:** state, counter and flags hold, and z=0.
- **clear=1:** on the next edge, state=0, match_count=0 and count_sat=0. clear has priority over en, and z is forced to 0 during the clear cycle.
- **Counter:**
  - match_count increments by 1 on each edge where z=1.
  - It holds at 2^CNT_W-1 rather than wrapping.
  - count_sat is set on the edge where the counter reaches its maximum and stays set until clear or reset.
- **Illegal parameters:** PAT_W outside 2..16 causes an elaboration error via a generate-time check.

## Timing
- **Reset (rstn=0, asynchronous):** state=0, z_q=0, match_count=0, count_sat=0.
  - z=0 because en is qualified by the reset state: z can only be 1 with s=PAT_W-1, and reset forces s=0.
- **Release:** rstn deasserts synchronously to clk externally. The first edge after release may consume a bit.
- **Latency of z:** 0 cycles. z is valid within the cycle that the completing bit is presented and is sampled at the same rising edge.
- **Latency of z_q:** 1 cycle after z.
- **Latency of match_count:** updated at the edge ending the match cycle; visible 1 cycle after z.
- **Reset during a partial match:** state returns to 0 immediately. The partial prefix is lost, and the next match needs the full PAT_W bits.
- **Saturation and clear on the same edge:** clear wins, and the counter ends at 0.
- **z=1 and en=0:** impossible, because z is gated by en.

## Test plan
1. **Non-overlap, default pattern.** Drive PATTERN=1101, overlap=0, en=1, stream 1,1,0,1,0,1,0,1,1,1,0,1,0,1,0.
   - z=1 on bits 4 and 12 only.
   - match_count=2 at the end.
   - z_q pulses one cycle after each z pulse.
2. **Overlap vs non-overlap.** Drive stream 1,1,0,1,1,0,1.
   - overlap=0: z only on bit 4, count=1.
   - overlap=1: z on bits 4 and 7, count=2.
3. **Enable gating.** Drive 1,1,0, then hold en=0 for 3 cycles with x=1, then en=1 with x=1.
   - z=0 during the en=0 gap.
   - z=1 on the final bit, so the state was held.
4. **Saturation.** Set CNT_W=2 and drive 5 back-to-back 1101 patterns with overlap=0.
   - match_count sticks at 3.
   - count_sat=1 from the 3rd match onward.
   - clear → count=0, sat=0.
5. **Mid-pattern reset.** Drive 1,1,0, then pulse rstn low mid-cycle, then 1.
   - The outputs drop to 0 asynchronously.
   - The following 1 gives no match; a full 1,1,0,1 afterwards gives z=1.
6. **Alternate parameters.** Set PAT_W=5, PATTERN=10100, overlap=1, stream 1,0,1,0,1,0,0.
   - z=1 on bit 7 only; no match on bit 5, since bits 1–5 are 10101.
   - Reaching that match requires the mismatch fallback at bit 5: the state drops from 4 to 3 (the partial prefix 101 is kept).
